// File: rtl/fetch_queue.sv
// In-order fetch-to-decode queue: compacts holey fetch groups into a circular buffer and retires decode-accepted prefixes.
// Optional same-cycle bypass from fetch to decode when empty: FETCH_QUEUE_BYPASS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module fetch_queue #(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ext_flush,
    input  logic [WIDTH-1:0]              in_valid,
    input  logic [WIDTH*ADDR_WIDTH-1:0]   in_pc,
    input  logic [WIDTH*32-1:0]           in_instr,
    input  logic [WIDTH-1:0]              in_guesses_branch,
    input  logic [WIDTH*ADDR_WIDTH-1:0]   in_prediction,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_valid,
    output logic [WIDTH*ADDR_WIDTH-1:0]   out_pc,
    output logic [WIDTH*32-1:0]           out_instr,
    output logic [WIDTH-1:0]              out_guesses_branch,
    output logic [WIDTH*ADDR_WIDTH-1:0]   out_prediction,
    input  logic [WIDTH-1:0]              out_ready,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
    logic [31:0]           mem_instr[DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pred [DEPTH];
    logic [DEPTH-1:0]      mem_gb;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] off [WIDTH];
    logic [CW-1:0] npush;
    logic [CW-1:0] pops;
    logic [CW-1:0] skip;
    logic          push_en;
    logic          bypass;
    logic          run;

    // Credit is taken from the registered count only, so out_ready never reaches in_ready.
    assign in_ready = reset && (count <= CW'(DEPTH - WIDTH));
    assign push_en  = in_ready && !ext_flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = push_en && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    // Each valid lane lands at its rank among the valid lanes below it.
    always_comb begin
        npush = '0;
        for (int i = 0; i < WIDTH; i++) begin
            off[i] = npush;
            npush  = npush + CW'(in_valid[i]);
        end
    end

    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            out_valid[j]                          = reset && !ext_flush && (count > CW'(j));
            out_pc[j*ADDR_WIDTH +: ADDR_WIDTH]    = mem_pc[head + PW'(j)];
            out_instr[j*32 +: 32]                 = mem_instr[head + PW'(j)];
            out_guesses_branch[j]                 = mem_gb[head + PW'(j)];
            out_prediction[j*ADDR_WIDTH +: ADDR_WIDTH] = mem_pred[head + PW'(j)];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            for (int j = 0; j < WIDTH; j++) begin
                out_valid[j]                          = npush > CW'(j);
                out_pc[j*ADDR_WIDTH +: ADDR_WIDTH]    = '0;
                out_instr[j*32 +: 32]                 = '0;
                out_guesses_branch[j]                 = 1'b0;
                out_prediction[j*ADDR_WIDTH +: ADDR_WIDTH] = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (in_valid[i] && off[i] == CW'(j)) begin
                        out_pc[j*ADDR_WIDTH +: ADDR_WIDTH]    = in_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
                        out_instr[j*32 +: 32]                 = in_instr[i*32 +: 32];
                        out_guesses_branch[j]                 = in_guesses_branch[i];
                        out_prediction[j*ADDR_WIDTH +: ADDR_WIDTH] = in_prediction[i*ADDR_WIDTH +: ADDR_WIDTH];
                    end
                end
            end
        end
`endif
    end

    // Only the lowest contiguous run of accepted lanes retires.
    always_comb begin
        pops = '0;
        run  = 1'b1;
        for (int j = 0; j < WIDTH; j++) begin
            run  = run & out_valid[j] & out_ready[j];
            pops = pops + CW'(run);
        end
    end

    // Bypassed lanes taken by decode are never written.
    assign skip = bypass ? pops : '0;

    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_valid[i] && off[i] >= skip) begin
                    mem_pc[tail + PW'(off[i] - skip)]    <= in_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_instr[tail + PW'(off[i] - skip)] <= in_instr[i*32 +: 32];
                    mem_gb[tail + PW'(off[i] - skip)]    <= in_guesses_branch[i];
                    mem_pred[tail + PW'(off[i] - skip)]  <= in_prediction[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || ext_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_en) begin
                tail <= tail + PW'(npush - skip);
            end
            head  <= head + PW'(pops - skip);
            count <= count + (push_en ? npush : '0) - pops;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (WIDTH=2, DEPTH=8, 32-bit PCs); covers FETCH_QUEUE_BYPASS_EN when defined.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        ext_flush;
    logic [1:0]  in_valid;
    logic [63:0] in_pc;
    logic [63:0] in_instr;
    logic [1:0]  in_guesses_branch;
    logic [63:0] in_prediction;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_pc;
    logic [63:0] out_instr;
    logic [1:0]  out_guesses_branch;
    logic [63:0] out_prediction;
    logic [1:0]  out_ready;
    logic [3:0]  count;

    int tests  = 0;
    int errors = 0;

    fetch_queue #(.WIDTH(2), .DEPTH(8), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .ext_flush(ext_flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_guesses_branch(in_guesses_branch), .in_prediction(in_prediction),
        .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_instr(out_instr), .out_guesses_branch(out_guesses_branch),
        .out_prediction(out_prediction), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        in_valid          = v;
        in_pc             = {pc1, pc0};
        in_instr          = {instr_of(pc1), instr_of(pc0)};
        in_prediction     = {pc1 + 32'd8, pc0 + 32'd8};
        in_guesses_branch = {pc1[2], pc0[2]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_drain(input logic [31:0] base);
        out_ready = 2'b00;
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, base + 32'(8 * k), base + 32'(8 * k + 4));
            step();
        end
        drive(2'b00, 32'h0, 32'h0);
        check("fill_count", 64'(count), 64'd8);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        drive(2'b01, 32'h300, 32'h0);
        step();
        drive(2'b00, 32'h0, 32'h0);
        check("drop_count", 64'(count), 64'd8);
        out_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            check("drain_pc0", 64'(out_pc[31:0]), 64'(base + 32'(8 * k)));
            check("drain_pc1", 64'(out_pc[63:32]), 64'(base + 32'(8 * k + 4)));
            step();
        end
        check("drain_empty", 64'(count), 64'd0);
        out_ready = 2'b00;
    endtask

    initial begin
        reset     = 1'b0;
        ext_flush = 1'b0;
        out_ready = 2'b00;
        drive(2'b00, 32'h0, 32'h0);
        step();
        step();
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("first_in_ready", 64'(in_ready), 64'd1);

`ifdef FETCH_QUEUE_BYPASS_EN
        drive(2'b11, 32'h400, 32'h404);
        out_ready = 2'b01;
        #1;
        check("byp_valid", 64'(out_valid), 64'd3);
        check("byp_pc0", 64'(out_pc[31:0]), 64'h400);
        step();
        drive(2'b00, 32'h0, 32'h0);
        out_ready = 2'b00;
        check("byp_count", 64'(count), 64'd1);
        check("byp_head", 64'(out_pc[31:0]), 64'h404);
        out_ready = 2'b11;
        step();
        check("byp_drain", 64'(count), 64'd0);
        out_ready = 2'b00;
`else
        drive(2'b11, 32'h400, 32'h404);
        #1;
        check("nobyp_latency", 64'(out_valid), 64'd0);
        drive(2'b00, 32'h0, 32'h0);
`endif

        // single push, full accept
        drive(2'b11, 32'h100, 32'h104);
        out_ready = 2'b11;
        step();
        drive(2'b00, 32'h0, 32'h0);
        check("push_valid", 64'(out_valid), 64'd3);
        check("push_pc", out_pc, {32'h104, 32'h100});
        check("push_instr0", 64'(out_instr[31:0]), 64'(instr_of(32'h100)));
        check("push_pred1", 64'(out_prediction[63:32]), 64'h10c);
        check("push_gb", 64'(out_guesses_branch), 64'd2);
        check("push_count", 64'(count), 64'd2);
        step();
        check("pop_count", 64'(count), 64'd0);
        check("pop_valid", 64'(out_valid), 64'd0);

        // hole compaction
        out_ready = 2'b00;
        drive(2'b10, 32'h0, 32'h208);
        step();
        drive(2'b00, 32'h0, 32'h0);
        check("hole_valid", 64'(out_valid), 64'd1);
        check("hole_pc0", 64'(out_pc[31:0]), 64'h208);
        check("hole_count", 64'(count), 64'd1);
        out_ready = 2'b11;
        step();
        check("hole_drain", 64'(count), 64'd0);

        fill_drain(32'h200);
        fill_drain(32'h500);

        // partial pop with concurrent push
        out_ready = 2'b00;
        drive(2'b11, 32'h600, 32'h604);
        step();
        drive(2'b01, 32'h608, 32'h0);
        step();
        drive(2'b00, 32'h0, 32'h0);
        check("pp_count3", 64'(count), 64'd3);
        out_ready = 2'b01;
        drive(2'b11, 32'h60c, 32'h610);
        step();
        drive(2'b00, 32'h0, 32'h0);
        out_ready = 2'b11;
        check("pp_count4", 64'(count), 64'd4);
        check("pp_order_a", out_pc, {32'h608, 32'h604});
        step();
        check("pp_order_b", out_pc, {32'h610, 32'h60c});
        step();
        check("pp_empty", 64'(count), 64'd0);

        // flush with a same-cycle push
        out_ready = 2'b00;
        drive(2'b11, 32'h700, 32'h704);
        step();
        drive(2'b11, 32'h708, 32'h70c);
        step();
        drive(2'b01, 32'h710, 32'h0);
        step();
        check("fl_count5", 64'(count), 64'd5);
        ext_flush = 1'b1;
        drive(2'b11, 32'h7a0, 32'h7a4);
        #1;
        check("fl_gate", 64'(out_valid), 64'd0);
        step();
        ext_flush = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        check("fl_count0", 64'(count), 64'd0);
        check("fl_valid0", 64'(out_valid), 64'd0);
        drive(2'b01, 32'h800, 32'h0);
        step();
        drive(2'b00, 32'h0, 32'h0);
        check("fl_after_valid", 64'(out_valid), 64'd1);
        check("fl_after_pc", 64'(out_pc[31:0]), 64'h800);

        // non-thermometer out_ready retires nothing when lane 0 is not ready
        drive(2'b11, 32'h810, 32'h814);
        step();
        drive(2'b00, 32'h0, 32'h0);
        out_ready = 2'b10;
        step();
        check("nt_count", 64'(count), 64'd3);
        check("nt_head", 64'(out_pc[31:0]), 64'h800);

        // reset mid-operation
        out_ready = 2'b00;
        reset = 1'b0;
        #1;
        check("mr_in_ready", 64'(in_ready), 64'd0);
        check("mr_valid", 64'(out_valid), 64'd0);
        step();
        check("mr_count", 64'(count), 64'd0);
        reset = 1'b1;
        step();
        check("mr_post_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
